gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 4, meaning counter and data width in bits (legal range 2..32).
REQ-002 The module SHALL provide parameter RESET_VAL, default 0, meaning the binary count loaded on reset.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  count enable, one step per cycle when high.
REQ-007 up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  load request, sampled each cycle.
REQ-009 load_bin  input  WIDTH  binary value for load.
REQ-010 bin  output  WIDTH  registered binary count.
REQ-011 G  output  WIDTH  registered Gray code of bin.
REQ-012 wrap  output  1  one-cycle pulse on wrap or saturation event.
REQ-013 dec_valid_in  input  1  decode-channel request valid.
REQ-014 dec_gray_in  input  WIDTH  Gray word to decode.
REQ-015 dec_valid_out  output  1  decode result valid.
REQ-016 dec_bin_out  output  WIDTH  decoded binary word.

Function
REQ-017 G SHALL always equal bin XOR (bin >> 1) in the same cycle, with no extra latency relative to bin.
REQ-018 Per-cycle priority SHALL be rst > load > en; with none active, bin, G, wrap=0 hold.
REQ-019 On load, bin SHALL take load_bin and G its Gray code next cycle, wrap=0, regardless of en/up.
REQ-020 On en & up, bin SHALL become (bin+1) mod 2^WIDTH; wrap=1 for one cycle when previous bin was all-ones.
REQ-021 On en & !up, bin SHALL become (bin-1) mod 2^WIDTH; wrap=1 for one cycle when previous bin was 0.
REQ-022 Every counting step SHALL change exactly one bit of G; load may change any number of bits.
REQ-023 Direction change SHALL take effect on the same cycle up changes, with no dead cycle.
REQ-024 Decode channel SHALL be independent of the counter, latency 1: dec_valid_out = dec_valid_in delayed one cycle.
REQ-025 dec_bin_out[WIDTH-1] SHALL equal dec_gray_in[WIDTH-1]; dec_bin_out[i] = dec_bin_out[i+1] XOR dec_gray_in[i] for lower bits.
REQ-026 dec_bin_out SHALL update only on cycles with dec_valid_in=1 and hold otherwise; back-to-back requests SHALL be accepted every cycle.

Reset
REQ-027 On rst, bin SHALL be RESET_VAL, G SHALL be RESET_VAL XOR (RESET_VAL>>1), wrap=0, dec_valid_out=0, dec_bin_out=0.
REQ-028 rst asserted mid-count or mid-decode SHALL override load, en and dec_valid_in in that cycle; no pending result survives.

Configuration
REQ-029 Macro GRAY_SAT_EN SHALL select saturation mode when defined.
REQ-030 With GRAY_SAT_EN defined, increment at all-ones and decrement at 0 SHALL hold bin/G unchanged and pulse wrap=1 for one cycle per attempted step.
REQ-031 Without GRAY_SAT_EN, counting SHALL wrap modulo 2^WIDTH as in REQ-020/REQ-021.

Verification (WIDTH=4, RESET_VAL=0)
REQ-032 rst=1 one cycle -> bin=0000, G=0000, wrap=0, dec_valid_out=0.
REQ-033 en=1, up=1 for 16 cycles -> G follows 0000,0001,0011,0010,...,1000 with single-bit changes; 16th step gives bin=0000, wrap=1 exactly once.
REQ-034 load=1, load_bin=0101, en=1 same cycle -> next cycle bin=0101, G=0111, wrap=0; then up=0 for 6 steps -> bin 0100..0000 then 1111 with wrap=1 on 0000->1111.
REQ-035 dec_valid_in=1 with dec_gray_in=1101 then 1000 on consecutive cycles -> dec_bin_out=1001 then 1111, dec_valid_out high for two cycles, one cycle late.
REQ-036 With GRAY_SAT_EN: load 1111 then en=1, up=1 for 3 cycles -> bin stays 1111, G=1000, wrap=1 each cycle.
REQ-037 rst asserted while en=1 at bin=0110 and dec_valid_in=1 -> next cycle bin=0000, G=0000, wrap=0, dec_valid_out=0.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output and an independent Gray-to-binary decode channel.
// Define GRAY_SAT_EN to make the counter saturate at its limits instead of wrapping.
module gray_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] G,
    output logic             wrap,
    input  logic             dec_valid_in,
    input  logic [WIDTH-1:0] dec_gray_in,
    output logic             dec_valid_out,
    output logic [WIDTH-1:0] dec_bin_out
);

    localparam logic [WIDTH-1:0] RST_BIN = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic             dec_valid_q;
    logic [WIDTH-1:0] dec_bin_q;

    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             at_min;

    assign at_max = &bin_q;
    assign at_min = ~|bin_q;

    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
            if (up) begin
                wrap_nxt = at_max;
`ifdef GRAY_SAT_EN
                bin_nxt  = at_max ? bin_q : bin_q + ONE;
`else
                bin_nxt  = bin_q + ONE;
`endif
            end else begin
                wrap_nxt = at_min;
`ifdef GRAY_SAT_EN
                bin_nxt  = at_min ? bin_q : bin_q - ONE;
`else
                bin_nxt  = bin_q - ONE;
`endif
            end
        end
    end

    // Gray is registered from the next binary value so it never lags bin.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q       <= RST_BIN;
            gray_q      <= to_gray(RST_BIN);
            wrap_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_bin_q   <= '0;
        end else begin
            bin_q       <= bin_nxt;
            gray_q      <= to_gray(bin_nxt);
            wrap_q      <= wrap_nxt;
            dec_valid_q <= dec_valid_in;
            if (dec_valid_in) begin
                dec_bin_q <= to_bin(dec_gray_in);
            end
        end
    end

    assign bin           = bin_q;
    assign G             = gray_q;
    assign wrap          = wrap_q;
    assign dec_valid_out = dec_valid_q;
    assign dec_bin_out   = dec_bin_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at WIDTH=4, RESET_VAL=0.
// Saturation checks are selected by GRAY_SAT_EN, matching the DUT build.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] bin;
    logic [3:0] G;
    logic       wrap;
    logic       dec_valid_in;
    logic [3:0] dec_gray_in;
    logic       dec_valid_out;
    logic [3:0] dec_bin_out;

    int checks   = 0;
    int failures = 0;
    int wraps    = 0;

    logic [3:0] gray_seq [16] = '{
        4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
        4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0
    };
    logic [3:0] down_seq [6] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF};
    logic [3:0] prev_g;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .up            (up),
        .load          (load),
        .load_bin      (load_bin),
        .bin           (bin),
        .G             (G),
        .wrap          (wrap),
        .dec_valid_in  (dec_valid_in),
        .dec_gray_in   (dec_gray_in),
        .dec_valid_out (dec_valid_out),
        .dec_bin_out   (dec_bin_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
        dec_valid_in = 1'b0; dec_gray_in = '0;
        step();
        check("rst_bin", bin, 0);
        check("rst_g", G, 0);
        check("rst_wrap", wrap, 0);
        check("rst_dvo", dec_valid_out, 0);
        check("rst_dbo", dec_bin_out, 0);

        rst = 1'b0; en = 1'b1; up = 1'b1;
        prev_g = G;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("up_bin%0d", i), bin, (i + 1) % 16);
            check($sformatf("up_g%0d", i), G, gray_seq[i]);
            check($sformatf("up_wrap%0d", i), wrap, (i == 15) ? 1 : 0);
            check($sformatf("up_1bit%0d", i), $countones(G ^ prev_g), 1);
            if (wrap) wraps++;
            prev_g = G;
        end
        check("up_wrap_count", wraps, 1);

        load = 1'b1; load_bin = 4'b0101; en = 1'b1; up = 1'b1;
        step();
        check("load_bin", bin, 4'b0101);
        check("load_g", G, 4'b0111);
        check("load_wrap", wrap, 0);

        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("dn_bin%0d", i), bin, down_seq[i]);
            check($sformatf("dn_wrap%0d", i), wrap, (i == 5) ? 1 : 0);
        end
        check("dn_g_last", G, 4'b1000);

        en = 1'b0;
        step();
        check("hold_bin", bin, 4'hF);
        check("hold_wrap", wrap, 0);

        en = 1'b1; up = 1'b1;
        step();
        check("dir_up_bin", bin, 4'h0);
        check("dir_up_wrap", wrap, 1);
        up = 1'b0;
        step();
        check("dir_dn_bin", bin, 4'hF);
        check("dir_dn_g", G, 4'b1000);
        check("dir_dn_wrap", wrap, 1);

        en = 1'b0;
        dec_valid_in = 1'b1; dec_gray_in = 4'b1101;
        #1;
        check("dec_pre_valid", dec_valid_out, 0);
        step();
        check("dec1_valid", dec_valid_out, 1);
        check("dec1_bin", dec_bin_out, 4'b1001);
        dec_gray_in = 4'b1000;
        step();
        check("dec2_valid", dec_valid_out, 1);
        check("dec2_bin", dec_bin_out, 4'b1111);
        dec_valid_in = 1'b0; dec_gray_in = 4'b0011;
        step();
        check("dec_idle_valid", dec_valid_out, 0);
        check("dec_hold_bin", dec_bin_out, 4'b1111);

        load = 1'b1; load_bin = 4'b0110;
        step();
        check("pre_rst_bin", bin, 4'b0110);
        load = 1'b0; en = 1'b1; up = 1'b1;
        dec_valid_in = 1'b1; dec_gray_in = 4'b0101; rst = 1'b1;
        step();
        check("mid_rst_bin", bin, 0);
        check("mid_rst_g", G, 0);
        check("mid_rst_wrap", wrap, 0);
        check("mid_rst_dvo", dec_valid_out, 0);
        check("mid_rst_dbo", dec_bin_out, 0);
        rst = 1'b0; dec_valid_in = 1'b0; en = 1'b0;

        load = 1'b1; load_bin = 4'hF;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
`ifdef GRAY_SAT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sat_bin%0d", i), bin, 4'hF);
            check($sformatf("sat_g%0d", i), G, 4'b1000);
            check($sformatf("sat_wrap%0d", i), wrap, 1);
        end
`else
        step();
        check("mod_bin", bin, 4'h0);
        check("mod_g", G, 4'h0);
        check("mod_wrap", wrap, 1);
`endif
        en = 1'b0;
        step();
        check("end_wrap", wrap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
